// File: rtl/bkm_irq_scheduler_if.sv
// Host-side register interface of the BKM-68X interrupt scheduler: card ID read,
// register 0x41 status/clear, register 0x31 video format and the card interrupt line.
interface bkm_irq_scheduler_if;
  logic [7:0] slot_no;
  logic       id_read;
  logic       clear_strobe;
  logic [7:0] clear_mask;
  logic [7:0] irq_status;
  logic       int_x;
  logic [7:0] reg_video_format;

  // Bus-side monitor block drives the requests and reads back the registers.
  modport master (
    output slot_no, id_read, clear_strobe, clear_mask,
    input  irq_status, int_x, reg_video_format
  );

  modport slave (
    input  slot_no, id_read, clear_strobe, clear_mask,
    output irq_status, int_x, reg_video_format
  );
endinterface

// File: rtl/bkm_irq_scheduler.sv
// BKM-68X host interrupt sequencer: boot, two timed readiness phases, debounced format events.
// Define IRQ_PARTIAL_CLEAR_EN to clear only the status bits written as 1 in register 0x41.
module bkm_irq_scheduler #(
  parameter int CLK_HZ        = 50000000,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic                 clk_50mhz_in,
  input  logic                 reset_x,
  input  logic [7:0]           video_format,
  output logic [7:0]           elapsed_s,
  bkm_irq_scheduler_if.slave   host
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [7:0] IRQ_NONE  = 8'hFF;
  localparam logic [7:0] IRQ_BOOT  = 8'hFD;
  localparam logic [7:0] IRQ_PH1   = 8'hFB;
  localparam logic [7:0] IRQ_PH2   = 8'hEF;
  localparam logic [7:0] IRQ_VFMT  = 8'hDF;

  typedef enum logic [1:0] {S_BOOT, S_P1, S_P2, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    irq_q, irq_d;
  logic [TW-1:0] tick_q;
  logic          id_seen_q;
  logic [7:0]    sample_q;
  logic [SW-1:0] stable_cnt_q;
  logic [7:0]    stable_fmt_q;
  logic          fmt_pending_q;
  logic [7:0]    reg_vf_q;
  logic [7:0]    th1, th2;
  logic          idle, consume, stable_hit;
  logic [7:0]    reg_vf_next;

  always_comb begin
    unique case (host.slot_no)
      8'h03:   begin th1 = 8'd14; th2 = 8'd21; end
      8'h04:   begin th1 = 8'd16; th2 = 8'd23; end
      default: begin th1 = 8'd12; th2 = 8'd19; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      tick_q    <= '0;
      elapsed_s <= 8'd0;
      id_seen_q <= 1'b0;
    end else begin
      if (tick_q == TW'(CLK_HZ - 1)) begin
        tick_q <= '0;
        if (elapsed_s != 8'hFF) elapsed_s <= elapsed_s + 8'd1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
      if (host.id_read) id_seen_q <= 1'b1;
    end
  end

  // Debounce: the hit fires once, on the cycle the counter reaches STABLE_CYCLES.
  assign stable_hit  = (video_format == sample_q) && (stable_cnt_q == SW'(STABLE_CYCLES - 1));
  // Compare against the value reg_video_format takes this edge, so a report in flight is honoured.
  assign reg_vf_next = consume ? stable_fmt_q : reg_vf_q;

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      sample_q      <= 8'h00;
      stable_cnt_q  <= '0;
      stable_fmt_q  <= 8'h00;
      fmt_pending_q <= 1'b0;
      reg_vf_q      <= 8'h00;
    end else begin
      sample_q <= video_format;
      if (video_format != sample_q)                stable_cnt_q <= '0;
      else if (stable_cnt_q != SW'(STABLE_CYCLES)) stable_cnt_q <= stable_cnt_q + 1'b1;

      if (stable_hit) begin
        stable_fmt_q  <= sample_q;
        fmt_pending_q <= (sample_q != reg_vf_next);
      end else if (consume) begin
        fmt_pending_q <= 1'b0;
      end
      if (consume) reg_vf_q <= stable_fmt_q;
    end
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= S_BOOT;
      irq_q   <= IRQ_BOOT;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  assign idle = (irq_q == IRQ_NONE);

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    consume = 1'b0;
    if (host.clear_strobe) begin
`ifdef IRQ_PARTIAL_CLEAR_EN
      irq_d = irq_q | host.clear_mask;
`else
      irq_d = IRQ_NONE;
`endif
    end
    // A clear in the same cycle suppresses any event; it re-evaluates on a later cycle.
    unique case (state_q)
      S_BOOT: if (idle) state_d = S_P1;
      S_P1: if (idle && id_seen_q && (elapsed_s > th1) && !host.clear_strobe) begin
        irq_d   = IRQ_PH1;
        state_d = S_P2;
      end
      S_P2: if (idle && (elapsed_s > th2) && !host.clear_strobe) begin
        irq_d   = IRQ_PH2;
        state_d = S_RUN;
      end
      S_RUN: if (idle && fmt_pending_q && !host.clear_strobe) begin
        irq_d   = IRQ_VFMT;
        consume = 1'b1;
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign host.irq_status       = irq_q;
  assign host.int_x            = &irq_q;
  assign host.reg_video_format = reg_vf_q;

endmodule

// File: tb/tb_bkm_irq_scheduler.sv
// Scoreboard bench for bkm_irq_scheduler: stimulus queues expected status changes,
// a negedge monitor compares them as irq_status moves.
module tb_bkm_irq_scheduler;

  logic       clk_50mhz_in = 1'b0;
  logic       reset_x      = 1'b0;
  logic [7:0] video_format = 8'h00;
  logic [7:0] elapsed_s;

  bkm_irq_scheduler_if bus ();

  bkm_irq_scheduler #(.CLK_HZ(100), .STABLE_CYCLES(50)) dut (
    .clk_50mhz_in (clk_50mhz_in),
    .reset_x      (reset_x),
    .video_format (video_format),
    .elapsed_s    (elapsed_s),
    .host         (bus)
  );

  always #10 clk_50mhz_in = ~clk_50mhz_in;

  typedef struct {
    logic [7:0] irq;
    logic [7:0] vf;
    logic [7:0] el;
    logic       chk_el;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] prev_irq = 8'hFD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_irq(input logic [7:0] irq, input logic [7:0] vf,
                            input logic [7:0] el, input logic chk_el);
    exp_t e;
    e.irq = irq; e.vf = vf; e.el = el; e.chk_el = chk_el;
    sb_q.push_back(e);
  endtask

  // Monitor: every change of irq_status out of reset must match the next queued entry.
  always @(negedge clk_50mhz_in) begin
    exp_t e;
    if (!reset_x) begin
      prev_irq = bus.irq_status;
    end else if (bus.irq_status !== prev_irq) begin
      prev_irq = bus.irq_status;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_irq: got %0h, expected no change", bus.irq_status);
      end else begin
        e = sb_q.pop_front();
        check("irq_status", bus.irq_status, e.irq);
        check("int_x", bus.int_x, (e.irq == 8'hFF));
        check("reg_video_format", bus.reg_video_format, e.vf);
        if (e.chk_el) check("elapsed_at_irq", elapsed_s, e.el);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_50mhz_in);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] slot);
    reset_x = 1'b0;
    bus.slot_no = slot;
    bus.id_read = 1'b0;
    bus.clear_strobe = 1'b0;
    bus.clear_mask = 8'h00;
    video_format = 8'h00;
    sb_q.delete();
    cycles(3);
    check("rst_irq_status", bus.irq_status, 8'hFD);
    check("rst_int_x", bus.int_x, 1'b0);
    check("rst_reg_video_format", bus.reg_video_format, 8'h00);
    check("rst_elapsed_s", elapsed_s, 8'h00);
    @(negedge clk_50mhz_in);
    reset_x = 1'b1;
    cycles(1);
  endtask

  task automatic pulse_clear(input logic [7:0] mask);
    bus.clear_strobe = 1'b1;
    bus.clear_mask   = mask;
    cycles(1);
    bus.clear_strobe = 1'b0;
    bus.clear_mask   = 8'h00;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk_50mhz_in);
      n++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: timeout, %0d expected events outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_elapsed(input logic [7:0] target, input int budget);
    int n = 0;
    while (elapsed_s != target && n < budget) begin
      @(posedge clk_50mhz_in);
      #1;
      n++;
    end
    check("wait_elapsed", elapsed_s, target);
  endtask

  initial begin
    // Boot, then the full two-phase sequence for slot 0x03 (th1=14, th2=21).
    do_reset(8'h03);
    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    pulse_clear(8'hFF);
    wait_empty("boot_clear", 10);

    wait_elapsed(8'd2, 400);
    bus.id_read = 1'b1;
    cycles(1);
    bus.id_read = 1'b0;
    expect_irq(8'hFB, 8'h00, 8'd15, 1'b1);
    wait_empty("phase1", 2000);

    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    expect_irq(8'hEF, 8'h00, 8'd22, 1'b1);
    pulse_clear(8'hFF);
    wait_empty("phase2", 1000);

    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    pulse_clear(8'hFF);
    wait_empty("phase2_clear", 10);

    // Glitchy format change: 0x02 for 20, 0x01 for 10, then 0x02 held.
    video_format = 8'h02;
    cycles(20);
    video_format = 8'h01;
    cycles(10);
    video_format = 8'h02;
    cycles(45);
    check("vf_not_early", bus.reg_video_format, 8'h00);
    check("no_irq_early", bus.irq_status, 8'hFF);
    expect_irq(8'hDF, 8'h02, 8'h00, 1'b0);
    wait_empty("format_report", 30);

    // Changes while 0xDF is outstanding coalesce; newest is reported after clear.
    video_format = 8'h03;
    cycles(60);
    video_format = 8'h04;
    cycles(60);
    check("df_held", bus.irq_status, 8'hDF);
    check("vf_held", bus.reg_video_format, 8'h02);
    expect_irq(8'hFF, 8'h02, 8'h00, 1'b0);
    expect_irq(8'hDF, 8'h04, 8'h00, 1'b0);
    pulse_clear(8'hFF);
    wait_empty("coalesced_report", 10);

    // Clear with a mask that excludes the boot bit.
    do_reset(8'h02);
`ifdef IRQ_PARTIAL_CLEAR_EN
    pulse_clear(8'h01);
    cycles(3);
    check("partial_keep_irq", bus.irq_status, 8'hFD);
    check("partial_keep_int_x", bus.int_x, 1'b0);
    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    pulse_clear(8'h02);
    wait_empty("partial_clear", 10);
`else
    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    pulse_clear(8'h01);
    wait_empty("full_clear_any_mask", 10);
`endif

    // No card ID read: phase 1 never fires and elapsed_s saturates.
    do_reset(8'h07);
    expect_irq(8'hFF, 8'h00, 8'h00, 1'b0);
    pulse_clear(8'hFF);
    wait_empty("noid_clear", 10);
    wait_elapsed(8'hFF, 27000);
    cycles(300);
    check("elapsed_saturated", elapsed_s, 8'hFF);
    check("noid_no_phase1", bus.irq_status, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bkm_irq_scheduler.md
# bkm_irq_scheduler

Sequences the BKM-68X host interrupt sequence on the 50 MHz clock domain: power-on, two timed readiness phases, and debounced video-format-change events. Owns the interrupt status byte the bus interface returns for register 0x41, and drives the active-low card interrupt line. Sits beside the bus-side monitor interface; that block forwards host reads/writes and a synchronized clear strobe.

## Interface
Parameters:
- CLK_HZ, 50000000, clock cycles per elapsed-seconds tick
- STABLE_CYCLES, 1000000, cycles video_format must hold before a change is accepted (20 ms)

Ports:
- clk_50mhz_in  in  1  system clock
- reset_x  in  1  asynchronous, active-low reset
- slot_no  in  8  option slot number written by host; selects thresholds
- id_read  in  1  one-cycle pulse: host read the card ID
- video_format  in  8  detected input format code (0x00 = no signal)
- clear_strobe  in  1  one-cycle pulse: host wrote register 0x41
- clear_mask  in  8  data byte of that write, valid with clear_strobe
- irq_status  out  8  register 0x41 read value, active-low event bits; 0xFF = none
- int_x  out  1  card interrupt, low while irq_status != 0xFF
- reg_video_format  out  8  last format reported to host (register 0x31)
- elapsed_s  out  8  seconds since reset, saturating

## Operation
- Reset values: irq_status=0xFD, int_x=0, reg_video_format=0x00, elapsed_s=0, state S_BOOT, id_seen=0, fmt_pending=0.
- Thresholds (th1/th2 in seconds): slot 0x02 → 12/19; 0x03 → 14/21; 0x04 → 16/23; any other value → 12/19. Decoded combinationally from slot_no, re-evaluated every cycle.
- Tick counter counts 0..CLK_HZ-1; on wrap, elapsed_s increments, saturating at 0xFF.
- id_seen: set on id_read pulse, cleared only by reset.
- Clear: on clear_strobe, irq_status <= 0xFF.
- "Idle" means registered irq_status == 0xFF.
- State machine:
  - S_BOOT: idle → S_P1.
  - S_P1: idle && id_seen && elapsed_s > th1 → irq_status=0xFB, S_P2.
  - S_P2: idle && elapsed_s > th2 → irq_status=0xEF, S_RUN.
  - S_RUN: idle && fmt_pending → reg_video_format <= stable format, irq_status=0xDF, fmt_pending=0.
- Debounce runs in every state:
  - Sample register and stable counter; any change in video_format resets the counter to 0.
  - Counter saturates at STABLE_CYCLES.
  - On reaching STABLE_CYCLES, if sample != reg_video_format, set fmt_pending and latch the sample as the stable format.
  - A later stable value overwrites the latched one (coalescing, latest wins).
  - fmt_pending is never reported before S_RUN.
  - A stable value equal to reg_video_format clears fmt_pending.

## Timing
- int_x is combinational from registered irq_status; it changes in the same cycle as irq_status.
- Clear latency: irq_status reads 0xFF on the cycle after clear_strobe.
- Events are evaluated against registered status, so a new event asserts no earlier than 2 cycles after clear_strobe.
- Clear and event conditions in the same cycle: the clear wins. The event fires on a following cycle if its condition still holds.
- Clear while already idle: no effect.
- Strict compare: phase 1 fires in the first cycle in which elapsed_s = th1+1 and the other conditions hold.
- Format report latency: STABLE_CYCLES+2 cycles after the last input change, if idle in S_RUN.
- Reset mid-sequence: all state returns to reset values immediately (asynchronous). Pending events are discarded.

## Configuration
- IRQ_PARTIAL_CLEAR_EN defined: clear applies irq_status <= irq_status | clear_mask. Only bits written as 1 are cleared, and int_x stays low until all bits are 1.
- Undefined: any write clears irq_status to 0xFF regardless of clear_mask.

## Test plan
- Reset, then clear_strobe with mask 0xFF → irq_status 0xFD→0xFF, int_x 0→1, state S_P1.
- slot_no=0x03, id_read pulse at 2 s, fast-sim CLK_HZ=100:
  - irq_status=0xFB when elapsed_s=15.
  - After clear, 0xEF when elapsed_s=22.
- No id_read pulse, elapsed_s reaches 0xFF → phase 1 never fires; elapsed_s holds 0xFF.
- In S_RUN, video_format 0x00→0x02, glitch to 0x01 for 10 cycles, then back to 0x02 (STABLE_CYCLES=50):
  - One 0xDF interrupt is raised.
  - reg_video_format=0x02 only after 50 stable cycles.
- Format change while 0xDF is outstanding:
  - No second interrupt is raised until clear.
  - Then 0xDF again with the newest format.
- IRQ_PARTIAL_CLEAR_EN defined, irq_status=0xFD, clear_mask=0x02 → 0xFF.
- IRQ_PARTIAL_CLEAR_EN defined, irq_status=0xFD, clear_mask=0x01 → stays 0xFD, int_x stays 0.
